wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Write-back stage, directly downstream of the MEM stage. Accepts one retired
//   instruction plus its result per give/get handshake. Writes rd into the register
//   file and pulses a scoreboard release to the hazard logic.
//   Maintains the retired-instruction counter and flags unknown opcodes.
// PARAMETERS
//   BITSIZE     32  data width of result / register-file write port
//   CNT_WIDTH   64  width of retired-instruction counter (wraps modulo 2^CNT_WIDTH)
// PORTS
//   clk               in   1          core clock, all state on rising edge
//   reset_i           in   1          synchronous reset, active-high
//   MEM_WB_give_i     in   1          MEM stage presents valid instr/data
//   WB_MEM_get_o      out  1          WB ready to accept (sampled by MEM)
//   MEM_WB_instr_i    in   32         raw instruction word from MEM
//   MEM_WB_data_i     in   BITSIZE    result (ALU result or extended load data)
//   WB_RF_we_o        out  1          register-file write enable
//   WB_RF_addr_o      out  5          register-file write address (instr[11:7])
//   WB_RF_data_o      out  BITSIZE    register-file write data
//   WB_release_o      out  1          one-cycle pulse: rd no longer pending
//   WB_release_rd_o   out  5          rd being released
//   WB_illegal_o      out  1          one-cycle pulse: unknown opcode retired
//   WB_instret_o      out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//   Reset (reset_i=1 at an edge): state<=GET; instr/data regs<=0; instret<=0.
//     While reset_i=1, every output is 0 (get_o forced 0). An in-flight WRITE is dropped.
//   FSM states: GET, WRITE.
//     GET:   get_o=1, all strobes 0. Transfer when get_o && give_i at the rising edge.
//            On transfer: latch instr, data; ->WRITE. Otherwise stay in GET.
//            give_i while get_o=0 is ignored. MEM must hold its payload until the transfer.
//     WRITE: get_o=0. RF_addr_o=instr[11:7], RF_data_o=data (both from registers).
//            Write-class opcodes: WB_RF_we_o=1 iff rd!=0. WB_release_o=1 iff rd!=0,
//              WB_release_rd_o=rd. Write-class = LUI 0110111, AUIPC 0010111,
//              JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
//            No-write opcodes: we=0, release=0. No-write = STORE 0100011,
//              BRANCH 1100011, MISC-MEM 0001111, SYSTEM 1110011.
//            Any other opcode: we=0, release=0, WB_illegal_o=1.
//            Every instruction: instret<=instret+1 at the edge that leaves WRITE; ->GET.
//   Latency: transfer edge E; RF write, release and illegal pulses are asserted in the
//     cycle after E. The register file commits at edge E+1. instret is updated at edge E+1.
//   Throughput: one instruction per 2 cycles, since get_o is low during WRITE.
//   When not in WRITE: we/release/illegal=0; RF_addr_o, RF_data_o, release_rd_o = 0.
//   instret at all-ones wraps to 0 with no flag. Output strobes are combinational
//     from registered state only, with no path from give_i to outputs.
// TESTING
//   1) OP instr 0x002081B3 (add x3,x1,x2), data 0x12345678 -> next cycle we=1,
//      addr=3, data=0x12345678, release=1/rd=3; instret 0->1.
//   2) LOAD to rd=0 (0x00002003), data 0xDEADBEEF -> we=0, release=0; instret +1.
//   3) STORE 0x00112023 and BRANCH 0x00208463 back-to-back -> no we/release;
//      get_o toggles 1,0,1,0; instret +2.
//   4) opcode 0x7F (instr 0x0000007F) -> illegal=1 for one cycle, we=0; instret +1.
//   5) reset_i=1 in cycle right after transfer -> no write, no release;
//      instret=0; get_o=0 during reset and 1 the cycle after reset deasserts.
//   6) preload instret=all-ones via force, retire one instr -> instret=0;
//      give_i held high with get_o=0 during WRITE -> no extra transfer.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: takes one retired instruction from MEM per give/get handshake,
// drives the register-file write port, releases rd to the hazard logic and counts retirements.
module wb_stage #(
  parameter int BITSIZE   = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 MEM_WB_give_i,
  output logic                 WB_MEM_get_o,
  input  logic [31:0]          MEM_WB_instr_i,
  input  logic [BITSIZE-1:0]   MEM_WB_data_i,
  output logic                 WB_RF_we_o,
  output logic [4:0]           WB_RF_addr_o,
  output logic [BITSIZE-1:0]   WB_RF_data_o,
  output logic                 WB_release_o,
  output logic [4:0]           WB_release_rd_o,
  output logic                 WB_illegal_o,
  output logic [CNT_WIDTH-1:0] WB_instret_o
);

  typedef enum logic {GET, WRITE} state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic is_write_class(input logic [6:0] opc);
    logic r;
    r = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_no_write(input logic [6:0] opc);
    logic r;
    r = 1'b0;
    case (opc)
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

  // Counter wraps silently at all-ones.
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    return v + CNT_WIDTH'(1);
  endfunction

  state_t                 state_q, state_nxt;
  logic [6:0]             opc_p1;
  logic [4:0]             rd_p1;
  logic [BITSIZE-1:0]     data_p1;
  logic [CNT_WIDTH-1:0]   instret_cnt;
  logic                   vld_p1;
  logic                   xfer_p0;
  logic                   instr_unused;

  // Only opcode and rd matter once the result is already computed.
  assign instr_unused = ^MEM_WB_instr_i[31:12];

  // Stage p0 -> p1: handshake capture
  assign xfer_p0 = (state_q == GET) && MEM_WB_give_i;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      GET:     if (MEM_WB_give_i) state_nxt = WRITE;
      WRITE:   state_nxt = GET;
      default: state_nxt = GET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= GET;
      opc_p1      <= '0;
      rd_p1       <= '0;
      data_p1     <= '0;
      instret_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      if (xfer_p0) begin
        opc_p1  <= MEM_WB_instr_i[6:0];
        rd_p1   <= MEM_WB_instr_i[11:7];
        data_p1 <= MEM_WB_data_i;
      end
      if (state_q == WRITE) instret_cnt <= cnt_inc(instret_cnt);
    end
  end

  // Stage p1: write-back outputs, from registered state only
  assign vld_p1 = (state_q == WRITE) && !reset_i;

  always_comb begin
    WB_MEM_get_o    = 1'b0;
    WB_RF_we_o      = 1'b0;
    WB_RF_addr_o    = '0;
    WB_RF_data_o    = '0;
    WB_release_o    = 1'b0;
    WB_release_rd_o = '0;
    WB_illegal_o    = 1'b0;
    WB_instret_o    = '0;
    if (!reset_i) begin
      WB_MEM_get_o = (state_q == GET);
      WB_instret_o = instret_cnt;
    end
    if (vld_p1) begin
      WB_RF_addr_o = rd_p1;
      WB_RF_data_o = data_p1;
      if (is_write_class(opc_p1) && (rd_p1 != 5'd0)) begin
        WB_RF_we_o      = 1'b1;
        WB_release_o    = 1'b1;
        WB_release_rd_o = rd_p1;
      end
      WB_illegal_o = !is_write_class(opc_p1) && !is_no_write(opc_p1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push hand-computed write-back
// responses; a negedge monitor pops and compares whenever the stage is in its write cycle.
module tb_wb_stage;
  localparam int BITSIZE   = 32;
  localparam int CNT_WIDTH = 64;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 give = 1'b0;
  logic                 get;
  logic [31:0]          instr = '0;
  logic [BITSIZE-1:0]   data = '0;
  logic                 we, rel, ill;
  logic [4:0]           addr, rel_rd;
  logic [BITSIZE-1:0]   rf_data;
  logic [CNT_WIDTH-1:0] instret;

  typedef struct {
    logic                 we;
    logic [4:0]           addr;
    logic [31:0]          data;
    logic                 rel;
    logic [4:0]           rd;
    logic                 ill;
    logic [CNT_WIDTH-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage #(.BITSIZE(BITSIZE), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset_i(reset_i),
    .MEM_WB_give_i(give), .WB_MEM_get_o(get),
    .MEM_WB_instr_i(instr), .MEM_WB_data_i(data),
    .WB_RF_we_o(we), .WB_RF_addr_o(addr), .WB_RF_data_o(rf_data),
    .WB_release_o(rel), .WB_release_rd_o(rel_rd),
    .WB_illegal_o(ill), .WB_instret_o(instret)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endfunction

  function automatic exp_t mk(logic w, logic [4:0] a, logic [31:0] d, logic r,
                              logic [4:0] rd, logic il, logic [CNT_WIDTH-1:0] c);
    exp_t e;
    e.we = w; e.addr = a; e.data = d; e.rel = r; e.rd = rd; e.ill = il; e.cnt = c;
    return e;
  endfunction

  // Monitor: WB presents a retirement whenever get is low outside reset.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (!get) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=we%0b addr%0d required=no_write", we, addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("we", 64'(we), 64'(e.we));
          chk("rf_addr", 64'(addr), 64'(e.addr));
          chk("rf_data", 64'(rf_data), 64'(e.data));
          chk("release", 64'(rel), 64'(e.rel));
          if (e.rel) chk("release_rd", 64'(rel_rd), 64'(e.rd));
          chk("illegal", 64'(ill), 64'(e.ill));
          chk("instret_in_write", instret, e.cnt);
        end
      end else begin
        chk("idle_outputs", {25'd0, we, rel, ill, addr, rel_rd, rf_data}, 64'd0);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] d, input bit push, input exp_t e);
    int waitc;
    waitc = 0;
    instr = ins;
    data  = d;
    give  = 1'b1;
    while (!get && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("get_high_before_transfer", 64'(get), 64'd1);
    if (!get) begin
      give = 1'b0;
      return;
    end
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    give = 1'b0;
    chk("get_low_in_write", 64'(get), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_get", 64'(get), 64'd0);
    chk("reset_strobes", {58'd0, we, rel, ill, addr == 5'd0 ? 1'b0 : 1'b1, 2'b00}, 64'd0);
    chk("reset_instret", instret, 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    #1;
    chk("get_after_reset", 64'(get), 64'd1);

    // 1) add x3,x1,x2
    send(32'h002081B3, 32'h12345678, 1, mk(1, 5'd3, 32'h12345678, 1, 5'd3, 0, 64'd0));
    // 2) load to x0
    send(32'h00002003, 32'hDEADBEEF, 1, mk(0, 5'd0, 32'hDEADBEEF, 0, 5'd0, 0, 64'd1));
    // 3) store then branch back-to-back
    send(32'h00112023, 32'h11111111, 1, mk(0, 5'd0, 32'h11111111, 0, 5'd0, 0, 64'd2));
    send(32'h00208463, 32'h22222222, 1, mk(0, 5'd8, 32'h22222222, 0, 5'd0, 0, 64'd3));
    // 4) unknown opcode 0x7F
    send(32'h0000007F, 32'h55AA55AA, 1, mk(0, 5'd0, 32'h55AA55AA, 0, 5'd0, 1, 64'd4));
    @(posedge clk); #1;
    chk("instret_after_4", instret, 64'd5);

    // 5) reset in the write cycle drops the instruction
    send(32'h002081B3, 32'hCAFEF00D, 0, mk(0, 5'd0, 32'h0, 0, 5'd0, 0, 64'd0));
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_write_we", 64'(we), 64'd0);
    chk("rst_write_release", 64'(rel), 64'd0);
    chk("rst_write_get", 64'(get), 64'd0);
    chk("rst_write_instret", instret, 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    #1;
    chk("get_after_rst_deassert", 64'(get), 64'd1);
    chk("instret_after_rst", instret, 64'd0);
    @(posedge clk); #1;

    // 6) wrap of the counter, give held high during WRITE
    @(negedge clk);
    force dut.instret_cnt = {CNT_WIDTH{1'b1}};
    @(posedge clk); #1;
    release dut.instret_cnt;
    chk("instret_preload", instret, {CNT_WIDTH{1'b1}});
    send(32'h00500293, 32'h00000005, 1, mk(1, 5'd5, 32'h5, 1, 5'd5, 0, {CNT_WIDTH{1'b1}}));
    give  = 1'b1;
    instr = 32'h0000007F;
    data  = 32'h99999999;
    @(posedge clk); #1;
    give = 1'b0;
    chk("instret_wrapped", instret, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_extra_transfer_instret", instret, 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
